div_sched: RTL and testbench



---
 rtl/div_sched.sv | 155 +++++++++++++++
 tb/tb_div_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
`default_nettype none
// ============================================================================
// Module   : div_sched
// Purpose  : Scheduler for the iterative divide/remainder unit off the E stage.
//            It launches the divider and tracks the one destination register
//            still pending. It raises a decode stall on RAW, WAW and
//            structural hazards, and it arbitrates the register-file write
//            port between the W stage and the divider result. The W stage
//            has priority until the divider result has waited STARVE_LIMIT
//            cycles.
// Options  : define DIV_SCHED_PERF_EN to add the divStallCnt output, a 32-bit
//            count of decode-stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module div_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       divIssueE,
    input  logic [4:0] rdE,
    input  logic       divD,
    input  logic [4:0] r1AddrD,
    input  logic [4:0] r2AddrD,
    input  logic [4:0] rdD,
    input  logic       regWriteD,
    input  logic       regWriteW,
    input  logic       divDone,
    output logic       divStart,
    output logic       divStallD,
    output logic       divWbEn,
    output logic [4:0] divWbRd,
    output logic       stallWB
`ifdef DIV_SCHED_PERF_EN
    ,
    output logic [31:0] divStallCnt
`endif
);

    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_RUN   = 2'd1;
    localparam logic [1:0]       S_WB    = 2'd2;
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state_q, state_d;
    logic [4:0]       pendRd_q, pendRd_d;
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;

    // The divider result has lost the write port for the maximum allowed number of cycles.
    logic atLimit;
    assign atLimit = (starveCnt_q == C_LIMIT);

    // State register, pending destination and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pendRd_q    <= 5'd0;
            starveCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pendRd_q    <= pendRd_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // Next-state logic. An issue outside IDLE is ignored because the scoreboard has only one entry.
    always_comb begin
        state_d     = state_q;
        pendRd_d    = pendRd_q;
        starveCnt_d = starveCnt_q;
        case (state_q)
            S_IDLE: begin
                if (divIssueE) begin
                    pendRd_d = rdE;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (divDone) begin
                    if (pendRd_q == 5'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_WB;
                        starveCnt_d = '0;
                    end
                end
            end
            S_WB: begin
                if (!regWriteW || atLimit) begin
                    state_d = S_IDLE;
                end else begin
                    starveCnt_d = starveCnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: launch, hazard stall, and write-port arbitration
    always_comb begin
        logic       pending;
        logic [4:0] effRd;
        pending   = 1'b0;
        effRd     = 5'd0;
        divStart  = 1'b0;
        divWbEn   = 1'b0;
        divWbRd   = 5'd0;
        stallWB   = 1'b0;

        if (state_q == S_IDLE) begin
            divStart = divIssueE;
            pending  = divIssueE;
            effRd    = rdE;
        end else begin
            pending  = 1'b1;
            effRd    = pendRd_q;
        end

        if (state_q == S_WB) begin
            divWbRd = pendRd_q;
            divWbEn = !regWriteW || atLimit;
            stallWB = regWriteW && atLimit;
        end

        // The stall holds through the write cycle, so D reads the updated register file on the following cycle.
        divStallD = (divD && ((state_q != S_IDLE) || divIssueE)) ||
                    (pending && (effRd != 5'd0) &&
                     ((r1AddrD == effRd) || (r2AddrD == effRd) ||
                      (regWriteD && (rdD == effRd))));
    end

`ifdef DIV_SCHED_PERF_EN
    logic [31:0] stallCnt_q;

    // Count decode-stall cycles, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= 32'd0;
        end else if (divStallD) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign divStallCnt = stallCnt_q;
`endif

`ifndef SYNTHESIS
    // Only one divide may be in flight at a time.
    a_no_issue_when_busy: assert property (@(posedge clk) disable iff (rst)
        !(divIssueE && (state_q != S_IDLE)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sched
// Purpose  : Directed, table-driven bench for div_sched. Each record is one
//            clock cycle of inputs together with the outputs expected before
//            the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       divIssueE;
    logic [4:0] rdE;
    logic       divD;
    logic [4:0] r1AddrD;
    logic [4:0] r2AddrD;
    logic [4:0] rdD;
    logic       regWriteD;
    logic       regWriteW;
    logic       divDone;
    logic       divStart;
    logic       divStallD;
    logic       divWbEn;
    logic [4:0] divWbRd;
    logic       stallWB;
`ifdef DIV_SCHED_PERF_EN
    logic [31:0] divStallCnt;
    int unsigned stallModel = 0;
`endif

    int nApplied = 0;
    int nMiss    = 0;

    always #5 clk = ~clk;

    div_sched #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .divIssueE (divIssueE),
        .rdE       (rdE),
        .divD      (divD),
        .r1AddrD   (r1AddrD),
        .r2AddrD   (r2AddrD),
        .rdD       (rdD),
        .regWriteD (regWriteD),
        .regWriteW (regWriteW),
        .divDone   (divDone),
        .divStart  (divStart),
        .divStallD (divStallD),
        .divWbEn   (divWbEn),
        .divWbRd   (divWbRd),
        .stallWB   (stallWB)
`ifdef DIV_SCHED_PERF_EN
        ,
        .divStallCnt (divStallCnt)
`endif
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       iss;
        logic [4:0] rdE;
        logic       divD;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rdD;
        logic       rwD;
        logic       rwW;
        logic       done;
        logic       eStart;
        logic       eStall;
        logic       eWbEn;
        logic [4:0] eWbRd;
        logic       eStallWB;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string name, logic r, logic iss, logic [4:0] rde,
                                logic dd, logic [4:0] r1, logic [4:0] r2, logic [4:0] rdd,
                                logic rwd, logic rww, logic done,
                                logic es, logic est, logic ew, logic [4:0] ewr, logic esw);
        vec_t v;
        v.name = name; v.rst = r; v.iss = iss; v.rdE = rde; v.divD = dd;
        v.r1 = r1; v.r2 = r2; v.rdD = rdd; v.rwD = rwd; v.rwW = rww; v.done = done;
        v.eStart = es; v.eStall = est; v.eWbEn = ew; v.eWbRd = ewr; v.eStallWB = esw;
        return v;
    endfunction

    // Drive one cycle of inputs, check the outputs before the next rising edge, and let that edge happen.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; divIssueE = v.iss; rdE = v.rdE; divD = v.divD;
        r1AddrD = v.r1; r2AddrD = v.r2; rdD = v.rdD; regWriteD = v.rwD;
        regWriteW = v.rwW; divDone = v.done;
        #1;
        nApplied++;
        if (divStart !== v.eStart || divStallD !== v.eStall || divWbEn !== v.eWbEn ||
            divWbRd !== v.eWbRd || stallWB !== v.eStallWB) begin
            nMiss++;
            $display("FAIL %s: got start=%0b stall=%0b wbEn=%0b wbRd=%0d stallWB=%0b, need start=%0b stall=%0b wbEn=%0b wbRd=%0d stallWB=%0b",
                     v.name, divStart, divStallD, divWbEn, divWbRd, stallWB,
                     v.eStart, v.eStall, v.eWbEn, v.eWbRd, v.eStallWB);
        end
`ifdef DIV_SCHED_PERF_EN
        if (divStallCnt !== stallModel) begin
            nMiss++;
            $display("FAIL %s_perf: divStallCnt=%0d, need %0d", v.name, divStallCnt, stallModel);
        end
        if (v.rst) stallModel = 0;
        else if (v.eStall) stallModel++;
`endif
    endtask

    initial begin
        rst = 1'b1; divIssueE = 1'b0; rdE = 5'd0; divD = 1'b0; r1AddrD = 5'd0;
        r2AddrD = 5'd0; rdD = 5'd0; regWriteD = 1'b0; regWriteW = 1'b0; divDone = 1'b0;
        repeat (2) @(posedge clk);

        //            name          rst iss rdE divD r1  r2  rdD rwD rwW done | st stl wb  rd  swb
        vq.push_back(mk("reset_st",    0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0,  0,  0,  0));
        // Test 1: RAW on rd 5, write, stall drops the cycle after the write
        vq.push_back(mk("t1_issue",    0, 1, 5,  0,  5,  0,  0,  0,  0,  0,   1, 1,  0,  0,  0));
        vq.push_back(mk("t1_run",      0, 0, 0,  0,  5,  0,  0,  0,  0,  0,   0, 1,  0,  0,  0));
        vq.push_back(mk("t1_done",     0, 0, 0,  0,  5,  0,  0,  0,  0,  1,   0, 1,  0,  0,  0));
        vq.push_back(mk("t1_wb",       0, 0, 0,  0,  5,  0,  0,  0,  0,  0,   0, 1,  1,  5,  0));
        vq.push_back(mk("t1_after",    0, 0, 0,  0,  5,  0,  0,  0,  0,  0,   0, 0,  0,  0,  0));
        // Test 2: rd 0 never stalls and is never written back
        vq.push_back(mk("t2_issue",    0, 1, 0,  0,  0,  0,  0,  0,  0,  0,   1, 0,  0,  0,  0));
        vq.push_back(mk("t2_run",      0, 0, 0,  0,  0,  0,  0,  1,  0,  0,   0, 0,  0,  0,  0));
        vq.push_back(mk("t2_done",     0, 0, 0,  0,  0,  0,  0,  0,  0,  1,   0, 0,  0,  0,  0));
        vq.push_back(mk("t2_idle",     0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0,  0,  0,  0));
        // Test 4: structural stall from a second div/rem in D
        vq.push_back(mk("t4_issDivD",  0, 1, 4,  1,  0,  0,  0,  0,  0,  0,   1, 1,  0,  0,  0));
        vq.push_back(mk("t4_runDivD",  0, 0, 0,  1,  0,  0,  0,  0,  0,  0,   0, 1,  0,  0,  0));
        vq.push_back(mk("t4_doneDivD", 0, 0, 0,  1,  0,  0,  0,  0,  0,  1,   0, 1,  0,  0,  0));
        vq.push_back(mk("t4_wb",       0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0,  1,  4,  0));
        vq.push_back(mk("t4_idleDivD", 0, 0, 0,  1,  0,  0,  0,  0,  0,  0,   0, 0,  0,  0,  0));
        // Test 5: WAW on rd 9 only when D writes rd; RAW via source 2
        vq.push_back(mk("t5_issue",    0, 1, 9,  0,  0,  0,  0,  0,  0,  0,   1, 0,  0,  0,  0));
        vq.push_back(mk("t5_waw",      0, 0, 0,  0,  0,  0,  9,  1,  0,  0,   0, 1,  0,  0,  0));
        vq.push_back(mk("t5_noWrite",  0, 0, 0,  0,  0,  0,  9,  0,  0,  0,   0, 0,  0,  0,  0));
        vq.push_back(mk("t5_rawSrc2",  0, 0, 0,  0,  0,  9,  0,  0,  0,  0,   0, 1,  0,  0,  0));
        vq.push_back(mk("t5_done",     0, 0, 0,  0,  0,  0,  0,  0,  0,  1,   0, 0,  0,  0,  0));
        vq.push_back(mk("t5_wb",       0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0,  1,  9,  0));
        // Test 6: reset while RUN, then a late divDone
        vq.push_back(mk("t6_issue",    0, 1, 3,  0,  0,  0,  0,  0,  0,  0,   1, 0,  0,  0,  0));
        vq.push_back(mk("t6_run",      0, 0, 0,  0,  3,  0,  0,  0,  0,  0,   0, 1,  0,  0,  0));
        vq.push_back(mk("t6_rstCyc",   1, 0, 0,  0,  3,  0,  0,  0,  0,  0,   0, 1,  0,  0,  0));
        vq.push_back(mk("t6_postRst",  0, 0, 0,  0,  3,  0,  0,  0,  0,  0,   0, 0,  0,  0,  0));
        vq.push_back(mk("t6_lateDone", 0, 0, 0,  0,  3,  0,  0,  0,  0,  1,   0, 0,  0,  0,  0));
        vq.push_back(mk("t6_stillIdle",0, 1, 2,  0,  0,  0,  0,  0,  0,  0,   1, 0,  0,  0,  0));
        vq.push_back(mk("t6_done",     0, 0, 0,  0,  0,  0,  0,  0,  0,  1,   0, 0,  0,  0,  0));
        vq.push_back(mk("t6_wb",       0, 0, 0,  0,  0,  0,  0,  0,  0,  0,   0, 0,  1,  2,  0));

        foreach (vq[i]) apply(vq[i]);

        // Test 3a: W stage holds the port; the write is forced on the fifth WB cycle
        apply(mk("t3_issue",  0, 1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        apply(mk("t3_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++)
            apply(mk($sformatf("t3_starve%0d", c), 0, 0, 0, 0, 7, 0, 0, 0, 1, 0,  0, 1, 0, 7, 0));
        apply(mk("t3_forced", 0, 0, 0, 0, 7, 0, 0, 0, 1, 0,  0, 1, 1, 7, 1));
        apply(mk("t3_idle",   0, 0, 0, 0, 7, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));

        // Test 3b: W stage releases the port on the second WB cycle
        apply(mk("t3b_issue", 0, 1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
        apply(mk("t3b_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        apply(mk("t3b_wb1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 7, 0));
        apply(mk("t3b_wb2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 7, 0));
        apply(mk("t3b_idle",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
`default_nettype wire
